// File: rtl/conv_layer_input_ctrl.sv
// conv_layer_input_ctrl
//
// Command sequencer sitting directly upstream of conv_layer_input_interface.
// Walks one IMAGE_SIZE x IMAGE_SIZE frame through
//    preload -> (shift -> load)* -> shift
// by issuing START codes on cmd and waiting for the matching FIN code on ack.
// Every finished shift produces one output row, reported on row_done/row_idx.
//
// Ports
//    clk           clock, rising edge
//    rst           synchronous active-high reset
//    start         one-cycle pulse, begins a frame when idle
//    abort         one-cycle pulse, cancels the current frame
//    ack[1:0]      from interface: 0 IDLE, 1 PRELOAD_FIN, 2 SHIFT_FIN, 3 LOAD_FIN
//    cmd[1:0]      to interface:   0 IDLE, 1 PRELOAD_START, 2 SHIFT_START, 3 LOAD_START
//    iface_enable  interface enable, high for the whole frame
//    busy          high from the cycle after start until back in IDLE
//    row_done      one-cycle pulse per finished output row
//    row_idx       index of the finished row, valid with row_done
//    done          one-cycle pulse, frame complete
//    err           sticky watchdog timeout flag
//
// Optional build macro CONV_CTRL_WATCHDOG_EN adds a per-wait-state watchdog
// (TIMEOUT_CYCLES). Without it, wait states wait forever and err is 0.
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | no frame in progress, waiting for start
// PRE_REQ  | PRELOAD_START on cmd for one cycle
// PRE_WAIT | waiting for PRELOAD_FIN
// SHF_REQ  | SHIFT_START on cmd for one cycle
// SHF_WAIT | waiting for SHIFT_FIN (one output row completes)
// LD_REQ   | LOAD_START on cmd for one cycle
// LD_WAIT  | waiting for LOAD_FIN
// DONE     | last row reported, done pulses on the way back to IDLE

module conv_layer_input_ctrl #(
    parameter int IMAGE_SIZE     = 8,
    parameter int KERNEL_SIZE    = 3,
    parameter int ROW_IDX_WIDTH  = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [1:0]               ack,
    output logic [1:0]               cmd,
    output logic                     iface_enable,
    output logic                     busy,
    output logic                     row_done,
    output logic [ROW_IDX_WIDTH-1:0] row_idx,
    output logic                     done,
    output logic                     err
);

    localparam int OUT_ROWS = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam logic [ROW_IDX_WIDTH-1:0] LAST_ROW = ROW_IDX_WIDTH'(OUT_ROWS - 1);

    localparam logic [1:0] CMD_IDLE          = 2'd0;
    localparam logic [1:0] CMD_PRELOAD_START = 2'd1;
    localparam logic [1:0] CMD_SHIFT_START   = 2'd2;
    localparam logic [1:0] CMD_LOAD_START    = 2'd3;

    localparam logic [1:0] ACK_PRELOAD_FIN   = 2'd1;
    localparam logic [1:0] ACK_SHIFT_FIN     = 2'd2;
    localparam logic [1:0] ACK_LOAD_FIN      = 2'd3;

    // Elaboration-time guard: row_idx must hold the last row index.
    if (OUT_ROWS < 1 || OUT_ROWS > (1 << ROW_IDX_WIDTH) || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("conv_layer_input_ctrl: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_REQ,
        S_PRE_WAIT,
        S_SHF_REQ,
        S_SHF_WAIT,
        S_LD_REQ,
        S_LD_WAIT,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [ROW_IDX_WIDTH-1:0] row_cnt_q, row_cnt_d;
    logic [1:0]               cmd_q, cmd_d;
    logic                     en_q, en_d;
    logic                     busy_q, busy_d;
    logic                     row_done_q, row_done_d;
    logic [ROW_IDX_WIDTH-1:0] row_idx_q, row_idx_d;
    logic                     done_q, done_d;
    logic                     start_ok;

`ifdef CONV_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            timeout;
    logic            in_wait;
`endif

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        row_done_d = 1'b0;
        row_idx_d  = row_idx_q;
        done_d     = 1'b0;
        start_ok   = start;

`ifdef CONV_CTRL_WATCHDOG_EN
        wd_d     = wd_q;
        err_d    = err_q;
        timeout  = 1'b0;
        start_ok = start & ~err_q;
        in_wait  = (state_q == S_PRE_WAIT) || (state_q == S_SHF_WAIT) ||
                   (state_q == S_LD_WAIT);
        // Down-counter is parked at the load value outside wait states, so it
        // starts fresh on every wait entry; terminal count at zero.
        if (in_wait) begin
            if (wd_q == '0) begin
                timeout = 1'b1;
            end else begin
                wd_d = wd_q - 1'b1;
            end
        end else begin
            wd_d = WD_LOAD;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (start_ok && !abort) begin
                    state_d   = S_PRE_REQ;
                    row_cnt_d = '0;
                end
            end
            S_PRE_REQ:  state_d = S_PRE_WAIT;
            S_PRE_WAIT: begin
                if (ack == ACK_PRELOAD_FIN) begin
                    state_d = S_SHF_REQ;
                end
            end
            S_SHF_REQ:  state_d = S_SHF_WAIT;
            S_SHF_WAIT: begin
                if (ack == ACK_SHIFT_FIN) begin
                    row_done_d = 1'b1;
                    row_idx_d  = row_cnt_q;
                    if (row_cnt_q == LAST_ROW) begin
                        state_d = S_DONE;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                        state_d   = S_LD_REQ;
                    end
                end
            end
            S_LD_REQ:   state_d = S_LD_WAIT;
            S_LD_WAIT: begin
                if (ack == ACK_LOAD_FIN) begin
                    state_d = S_SHF_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default:    state_d = S_IDLE;
        endcase

`ifdef CONV_CTRL_WATCHDOG_EN
        // An awaited ack arriving on the terminal cycle still counts.
        if (timeout && (state_d == state_q)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
`endif

        // Abort overrides everything, including an ack in the same cycle.
        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            row_cnt_d  = row_cnt_q;
            row_done_d = 1'b0;
            row_idx_d  = row_idx_q;
            done_d     = 1'b0;
`ifdef CONV_CTRL_WATCHDOG_EN
            err_d      = err_q;
`endif
        end

        // Outputs are registered decodes of the next state.
        case (state_d)
            S_PRE_REQ: cmd_d = CMD_PRELOAD_START;
            S_SHF_REQ: cmd_d = CMD_SHIFT_START;
            S_LD_REQ:  cmd_d = CMD_LOAD_START;
            default:   cmd_d = CMD_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        en_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            row_cnt_q  <= '0;
            cmd_q      <= CMD_IDLE;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            row_done_q <= 1'b0;
            row_idx_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            cmd_q      <= cmd_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            row_done_q <= row_done_d;
            row_idx_q  <= row_idx_d;
            done_q     <= done_d;
        end
    end

`ifdef CONV_CTRL_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= WD_LOAD;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign cmd          = cmd_q;
    assign iface_enable = en_q;
    assign busy         = busy_q;
    assign row_done     = row_done_q;
    assign row_idx      = row_idx_q;
    assign done         = done_q;

endmodule
